// File: rtl/intersection_liveness_monitor.sv
`default_nettype none
// ============================================================================
// Module   : intersection_liveness_monitor
// Purpose  : Passive runtime monitor for the intersection controller. For
//            each request/green channel it checks that green follows a
//            request within MAX_WAIT cycles. It also checks that no
//            conflicting pair of greens is ever lit together. It keeps
//            sticky error flags, the worst observed latency per channel and
//            a saturating violation counter. It only observes; it never
//            drives the lights.
// Ports    : clock      - system clock, rising edge
//            reset      - asynchronous reset, active low
//            req        - per-channel service request (level)
//            green      - per-channel green indication
//            clear      - synchronous clear of sticky/statistics state
//            sel        - channel select for max_wait readout
//            pending    - request latched, green not yet seen
//            timeout    - sticky deadline-missed flag per channel
//            conflict   - sticky conflicting-green flag
//            err        - OR of timeout bits and conflict
//            max_wait   - worst recorded latency of channel sel
//            viol_count - saturating count of violation events
// Revision : 1.0 - initial release
// ============================================================================
module intersection_liveness_monitor #(
  parameter int NUM_CHAN = 4,
  parameter int MAX_WAIT = 25,
  parameter int CNT_W    = 8,
  parameter logic [NUM_CHAN*NUM_CHAN-1:0] CONFLICT_MASK = 16'h799E,
  parameter int VCNT_W   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CHAN-1:0]         req,
  input  logic [NUM_CHAN-1:0]         green,
  input  logic                        clear,
  input  logic [$clog2(NUM_CHAN)-1:0] sel,
  output logic [NUM_CHAN-1:0]         pending,
  output logic [NUM_CHAN-1:0]         timeout,
  output logic                        conflict,
  output logic                        err,
  output logic [CNT_W-1:0]            max_wait,
  output logic [VCNT_W-1:0]           viol_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  // Enough width for every channel timing out plus a conflict in one cycle.
  localparam int EV_W = $clog2(NUM_CHAN + 2);

  logic [NUM_CHAN-1:0]            to_evt_v;
  logic [NUM_CHAN-1:0][CNT_W-1:0] mw_all;

  // --------------------------------------------------------------------------
  // Per-channel deadline tracker
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             pend;
    logic             to_evt;
    logic             rec_vld;
    logic [CNT_W-1:0] rec_lat;
    logic             to_reg;
    logic [CNT_W-1:0] mw_reg;
    logic [CNT_W-1:0] mw_base;
    logic [CNT_W-1:0] mw_nxt;

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // State register
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // Next-state logic. cnt counts cycles since the latching request, so
    // it also keeps counting on the transition into EXPIRED.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        ST_IDLE: begin
          if (req[i] && !green[i]) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_W'(1);
          end else begin
            cnt_nxt   = '0;
          end
        end
        ST_WAIT: begin
          if (green[i]) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt == MAX_WAIT_C) state_nxt = ST_EXPIRED;
          end
        end
        ST_EXPIRED: begin
          if (green[i]) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt_inc;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Output logic: pending flag, timeout event and latency recording.
    // A request served in the same cycle it arrives records latency 0.
    always_comb begin
      pend    = (state == ST_WAIT) || (state == ST_EXPIRED);
      to_evt  = (state == ST_WAIT) && !green[i] && (cnt == MAX_WAIT_C);
      rec_vld = green[i] && (pend || (state == ST_IDLE && req[i]));
      rec_lat = pend ? cnt : '0;
    end

    // A new event in the same cycle as clear survives the clear.
    assign mw_base = clear ? '0 : mw_reg;
    assign mw_nxt  = (rec_vld && (rec_lat > mw_base)) ? rec_lat : mw_base;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        to_reg <= 1'b0;
        mw_reg <= '0;
      end else begin
        to_reg <= (to_reg && !clear) || to_evt;
        mw_reg <= mw_nxt;
      end
    end

    assign pending[i]  = pend;
    assign timeout[i]  = to_reg;
    assign to_evt_v[i] = to_evt;
    assign mw_all[i]   = mw_reg;
  end

  // --------------------------------------------------------------------------
  // Conflicting-green detection (upper triangle of the mask only)
  // --------------------------------------------------------------------------
  logic conf_now;

  always_comb begin
    conf_now = 1'b0;
    for (int a = 0; a < NUM_CHAN; a++) begin
      for (int b = a + 1; b < NUM_CHAN; b++) begin
        if (CONFLICT_MASK[a*NUM_CHAN+b] && green[a] && green[b]) conf_now = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Violation counter and sticky conflict flag
  // --------------------------------------------------------------------------
  logic              conflict_r;
  logic [VCNT_W-1:0] viol_r;
  logic [EV_W-1:0]   ev_cnt;
  logic [VCNT_W-1:0] vc_base;
  logic [VCNT_W:0]   vc_sum;
  logic [VCNT_W-1:0] vc_nxt;

  always_comb begin
    ev_cnt = EV_W'(conf_now);
    for (int k = 0; k < NUM_CHAN; k++) begin
      ev_cnt = ev_cnt + EV_W'(to_evt_v[k]);
    end
    vc_base = clear ? '0 : viol_r;
    vc_sum  = {1'b0, vc_base} + (VCNT_W+1)'(ev_cnt);
    // Carry out of the top bit means the counter would wrap: hold at max.
    vc_nxt  = vc_sum[VCNT_W] ? {VCNT_W{1'b1}} : vc_sum[VCNT_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_r <= 1'b0;
      viol_r     <= '0;
    end else begin
      conflict_r <= (conflict_r && !clear) || conf_now;
      viol_r     <= vc_nxt;
    end
  end

  assign conflict   = conflict_r;
  assign err        = (|timeout) || conflict_r;
  assign max_wait   = mw_all[sel];
  assign viol_count = viol_r;

endmodule
`default_nettype wire

// File: doc/intersection_liveness_monitor.md
Name: intersection_liveness_monitor

Overview:
Synthesizable runtime monitor for the intersection controller. It generalises the formal pedestrian liveness check to NUM_CHAN request/green channels, each with a bounded-wait deadline, and adds a parametrised conflicting-green check. It also keeps sticky error flags, worst-case latency capture and a violation counter. It sits beside the intersection top level, observes request and green lines only, and drives a status/error interface; it never affects light control.

Parameters:
NUM_CHAN, 4, number of request/green channel pairs (ch0 pedestrian, ch1 up, ch2 down, ch3 turn by default).
MAX_WAIT, 25, max cycles from request to green; green at req cycle + MAX_WAIT is legal.
CNT_W, 8, wait counter width; must satisfy 2^CNT_W - 1 > MAX_WAIT.
CONFLICT_MASK, 16'h799E, NUM_CHAN*NUM_CHAN bits; bit i*NUM_CHAN+j set means green[i] and green[j] must never be high together; must be symmetric with zero diagonal.
VCNT_W, 16, violation counter width.

Ports:
clock  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (low = in reset).
req  input  NUM_CHAN  per-channel service request (button/sensor), level, any duration.
green  input  NUM_CHAN  per-channel green indication from the controller.
clear  input  1  synchronous clear of sticky/statistics state.
sel  input  $clog2(NUM_CHAN)  channel select for max_wait readout.
pending  output  NUM_CHAN  request latched, green not yet seen.
timeout  output  NUM_CHAN  sticky: deadline missed on that channel.
conflict  output  1  sticky: a conflicting green pair was observed.
err  output  1  OR of timeout bits and conflict.
max_wait  output  CNT_W  worst latency recorded on channel sel.
viol_count  output  VCNT_W  saturating count of violation events.

Behaviour:
- Reset (reset low, async): all per-channel state IDLE, counters 0, pending=0, timeout=0, conflict=0, err=0, all max_wait registers 0, viol_count=0.
- Per-channel FSM: IDLE, WAIT, EXPIRED. cnt[i] is CNT_W wide and saturates at all-ones.
- IDLE: req&green -> stay IDLE, record latency 0. req&!green -> WAIT, cnt<=1. No req -> stay.
- WAIT (cnt = cycles since the latching req cycle): green -> IDLE, record latency cnt. !green & cnt==MAX_WAIT -> EXPIRED, set timeout[i], count one violation. Otherwise cnt<=cnt+1.
- EXPIRED: cnt keeps incrementing (saturating). green -> IDLE, record latency cnt.
- pending[i]=1 in WAIT and EXPIRED. Outputs are registered, so the flag appears one cycle after the deciding edge.
- A new req while in WAIT or EXPIRED is absorbed. The oldest request sets the deadline. A req released before green still stays pending.
- Record latency: max_wait_reg[i] <= max(max_wait_reg[i], latency).
- Conflict: each cycle, if any pair i<j with mask bit set has green[i]&green[j], then conflict<=1 and viol_count increments once for that cycle. Multiple pairs in one cycle count as one.
- viol_count: may increment by up to NUM_CHAN+1 in one cycle (simultaneous timeouts plus conflict). Saturates at all-ones, no wrap.
- clear: zeroes timeout, conflict, max_wait regs and viol_count. It does not alter FSM state, cnt or pending.
- clear in the same cycle as a new violation: the violation wins (flag set, viol_count=1 or number of events).
- An EXPIRED channel whose timeout was cleared does not re-flag until a new request times out.
- Reset asserted mid-wait aborts tracking immediately. No flag is raised for a request in flight at reset.

Test Plan:
- req[0] pulse at cycle 10, green[0] high at cycle 35 -> no timeout, pending[0] high cycles 11..35, max_wait(sel=0)=25.
- req[0] at cycle 10, green[0] at cycle 36 -> timeout[0]=1 and err=1 from cycle 36 output, viol_count=1. Green at 36 returns to IDLE; max_wait=26.
- green[1]&green[2] high 5 cycles -> conflict stays 0. green[1]&green[3] high 3 cycles -> conflict=1, viol_count=3.
- req[3] re-asserted every cycle for 30 cycles, green never -> single timeout at cycle req+25, viol_count=1; pending stays 1.
- Timeout on ch2, then clear with no new event -> timeout, conflict, viol_count and max_wait return to 0; pending untouched. Clear coincident with a ch1 timeout -> timeout[1]=1, viol_count=1.
- reset low at cycle req+20 while WAIT, released 3 cycles later, green never -> no timeout, all outputs 0.
